// File: rtl/instr_sequencer.sv
// Program-driven instruction source for simple_cpu: small program RAM loaded while idle,
// then issued word by word with per-class hold times. Optional macro SEQ_LOOP_EN wraps pc at the last address.
module instr_sequencer #(
    parameter int INSTR_WIDTH    = 20,
    parameter int PROG_ADDR_BITS = 4,
    parameter int ALU_HOLD       = 3,
    parameter int LOAD_HOLD      = 4,
    parameter int STORE_HOLD     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_we,
    input  logic [PROG_ADDR_BITS-1:0] prog_addr,
    input  logic [INSTR_WIDTH-1:0]    prog_data,
    input  logic                      start,
    output logic [INSTR_WIDTH-1:0]    instruction,
    output logic                      instr_valid,
    output logic                      busy,
    output logic                      done,
    output logic [PROG_ADDR_BITS-1:0] pc
);

    localparam int DEPTH    = 1 << PROG_ADDR_BITS;
    localparam int ALU_H    = (ALU_HOLD   < 1) ? 1 : ALU_HOLD;
    localparam int LOAD_H   = (LOAD_HOLD  < 1) ? 1 : LOAD_HOLD;
    localparam int STORE_H  = (STORE_HOLD < 1) ? 1 : STORE_HOLD;
    localparam int HOLD_M1  = (ALU_H > LOAD_H) ? ALU_H : LOAD_H;
    localparam int HOLD_MAX = (HOLD_M1 > STORE_H) ? HOLD_M1 : STORE_H;
    localparam int CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    logic [INSTR_WIDTH-1:0]    mem_q [DEPTH];
    state_t                    state_q;
    logic [INSTR_WIDTH-1:0]    instr_q;
    logic                      valid_q;
    logic                      busy_q;
    logic                      done_q;
    logic [PROG_ADDR_BITS-1:0] pc_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [PROG_ADDR_BITS-1:0] pc_d;
    logic [INSTR_WIDTH-1:0]    next_word;
    logic [INSTR_WIDTH-1:0]    first_word;
    logic [CNT_W-1:0]          hold_last;
    logic                      hold_end;
    logic                      at_last;
    logic                      end_run;

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] w);
        return w[INSTR_WIDTH-1 -: 2] == 2'b00;
    endfunction

    always_comb begin
        pc_d       = pc_q + PROG_ADDR_BITS'(1);
        next_word  = mem_q[pc_d];
        first_word = mem_q[0];
        case (instr_q[INSTR_WIDTH-1 -: 2])
            2'b01:   hold_last = CNT_W'(ALU_H - 1);
            2'b10:   hold_last = CNT_W'(LOAD_H - 1);
            default: hold_last = CNT_W'(STORE_H - 1);
        endcase
        hold_end = (cnt_q == hold_last);
        at_last  = (pc_q == '1);
`ifdef SEQ_LOOP_EN
        // pc_d wraps to 0 at the last address, so only a HALT word ends the run
        end_run  = is_halt(next_word) | (at_last & 1'b0);
`else
        end_run  = at_last | is_halt(next_word);
`endif
    end

    // Program RAM: synchronous write, writable only while idle; contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        pc_q  <= '0;
                        cnt_q <= '0;
                        if (is_halt(first_word)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            instr_q <= first_word;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (hold_end) begin
                        cnt_q <= '0;
                        if (end_run) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            instr_q <= '0;
                        end else begin
                            pc_q    <= pc_d;
                            instr_q <= next_word;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table of programs with hand-derived totals,
// a per-cycle trace scoreboard, and hand-written reset / write-during-run sequences.
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic [19:0] instruction;
    logic        instr_valid;
    logic        busy;
    logic        done;
    logic [3:0]  pc;

    instr_sequencer #(
        .INSTR_WIDTH(20),
        .PROG_ADDR_BITS(4),
        .ALU_HOLD(3),
        .LOAD_HOLD(4),
        .STORE_HOLD(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .start(start),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .busy(busy),
        .done(done),
        .pc(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] instr;
        logic        valid;
        logic        busy;
        logic        done;
        logic [3:0]  pc;
        logic        chk_pc;
    } exp_t;

    typedef struct {
        logic [19:0] w0, w1, w2, w3;
        int          exp_vcyc;
        logic [3:0]  exp_pc;
    } vec_t;

    exp_t        sb[$];
    logic [19:0] model_mem [16];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endfunction

    function automatic int hold_of(input logic [19:0] w);
        case (w[19:18])
            2'b01:   return 3;
            2'b10:   return 4;
            2'b11:   return 3;
            default: return 0;
        endcase
    endfunction

    // Expected per-cycle trace from the model program, starting the sample after the start edge
    function automatic void push_trace();
        int unsigned a = 0;
        logic [3:0]  last = 4'd0;
        exp_t        e;
        while (1) begin
            if (model_mem[a][19:18] == 2'b00) break;
            for (int k = 0; k < hold_of(model_mem[a]); k++) begin
                e = '{instr: model_mem[a], valid: 1'b1, busy: 1'b1, done: 1'b0, pc: 4'(a), chk_pc: 1'b1};
                sb.push_back(e);
            end
            last = 4'(a);
            if (a == 15) break;
            a++;
        end
        e = '{instr: 20'h0, valid: 1'b0, busy: 1'b0, done: 1'b1, pc: last, chk_pc: 1'b1};
        sb.push_back(e);
        e = '{instr: 20'h0, valid: 1'b0, busy: 1'b0, done: 1'b0, pc: 4'h0, chk_pc: 1'b0};
        sb.push_back(e);
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = model_mem[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run_check(input bit we_start, input bit we_run, input logic [3:0] wa,
                             input logic [19:0] wd, output int vcyc, output logic [3:0] dpc,
                             output bit done_seen);
        exp_t e;
        int   cycles = 0;
        vcyc = 0; dpc = 4'hx; done_seen = 1'b0;
        push_trace();
        @(negedge clk);
        start = 1'b1;
        if (we_start) begin
            prog_we = 1'b1; prog_addr = wa; prog_data = wd;
        end
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        if (we_start) model_mem[wa] = wd;
        while (sb.size() != 0) begin
            if (cycles >= 300) begin
                chk("trace_budget", 32'(cycles), 32'd0);
                sb.delete();
                break;
            end
            e = sb.pop_front();
            chk("trace", {instruction, instr_valid, busy, done}, {e.instr, e.valid, e.busy, e.done});
            if (e.chk_pc) chk("trace_pc", 32'(pc), 32'(e.pc));
            if (instr_valid) vcyc++;
            if (done) begin done_seen = 1'b1; dpc = pc; end
            prog_we = we_run && (cycles == 1); prog_addr = wa; prog_data = wd;
            @(negedge clk);
            prog_we = 1'b0;
            cycles++;
        end
    endtask

    vec_t        tbl[4];
    int          vcyc;
    logic [3:0]  dpc;
    bit          dseen;

    initial begin
        tbl[0] = '{w0: 20'h47000, w1: 20'h53000, w2: 20'h00000, w3: 20'h00000, exp_vcyc: 6,  exp_pc: 4'd1};
        tbl[1] = '{w0: 20'hB80F0, w1: 20'h00000, w2: 20'h00000, w3: 20'h00000, exp_vcyc: 4,  exp_pc: 4'd0};
        tbl[2] = '{w0: 20'h00000, w1: 20'h47000, w2: 20'h00000, w3: 20'h00000, exp_vcyc: 0,  exp_pc: 4'd0};
        tbl[3] = '{w0: 20'hC1234, w1: 20'h8ABCD, w2: 20'h47000, w3: 20'h00000, exp_vcyc: 10, exp_pc: 4'd2};

        rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
        #12;
        chk("reset_outputs", {instruction, instr_valid, busy, done, pc}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) model_mem[i] = 20'h0;
            model_mem[0] = tbl[t].w0; model_mem[1] = tbl[t].w1;
            model_mem[2] = tbl[t].w2; model_mem[3] = tbl[t].w3;
            load_prog();
            run_check(1'b0, 1'b0, 4'h0, 20'h0, vcyc, dpc, dseen);
            chk("tbl_valid_cycles", 32'(vcyc), 32'(tbl[t].exp_vcyc));
            chk("tbl_done_pc", 32'(dpc), 32'(tbl[t].exp_pc));
            chk("tbl_done_seen", 32'(dseen), 32'd1);
        end

        // Full program with no HALT word
        for (int i = 0; i < 16; i++) model_mem[i] = 20'h47000;
        load_prog();
`ifndef SEQ_LOOP_EN
        run_check(1'b0, 1'b0, 4'h0, 20'h0, vcyc, dpc, dseen);
        chk("full_valid_cycles", 32'(vcyc), 32'd48);
        chk("full_done_pc", 32'(dpc), 32'd15);
`else
        begin
            int  done_cnt = 0;
            bit  seen15 = 1'b0, wrapped = 1'b0;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int c = 0; c < 120; c++) begin
                if (done) done_cnt++;
                if (pc == 4'd15) seen15 = 1'b1;
                if (seen15 && pc == 4'd0 && instr_valid) wrapped = 1'b1;
                @(negedge clk);
            end
            chk("loop_no_done", 32'(done_cnt), 32'd0);
            chk("loop_wrap", 32'(wrapped), 32'd1);
            #2 rst = 1'b0;
            @(negedge clk); rst = 1'b1;
        end
`endif

        // Reset during the second instruction, then rerun with the program intact
        for (int i = 0; i < 16; i++) model_mem[i] = 20'h0;
        model_mem[0] = 20'h47000; model_mem[1] = 20'h53000;
        load_prog();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_instr", 32'(instruction), 32'h53000);
        chk("pre_rst_pc", 32'(pc), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outputs", {instruction, instr_valid, busy, done, pc}, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {instruction, instr_valid, busy, done}, 32'h0);
        run_check(1'b0, 1'b0, 4'h0, 20'h0, vcyc, dpc, dseen);
        chk("rerun_valid_cycles", 32'(vcyc), 32'd6);

        // Write during RUN is ignored, both in the run itself and in the rerun
        run_check(1'b0, 1'b1, 4'd1, 20'h7FFFF, vcyc, dpc, dseen);
        chk("we_run_valid_cycles", 32'(vcyc), 32'd6);
        run_check(1'b0, 1'b0, 4'h0, 20'h0, vcyc, dpc, dseen);
        chk("we_run_rerun_pc", 32'(dpc), 32'd1);

        // start together with a write to address 0: fetch sees the old word, rerun the new one
        for (int i = 0; i < 16; i++) model_mem[i] = 20'h0;
        model_mem[0] = 20'h47000;
        load_prog();
        run_check(1'b1, 1'b0, 4'd0, 20'hB80F0, vcyc, dpc, dseen);
        chk("we_start_old_word", 32'(vcyc), 32'd3);
        run_check(1'b0, 1'b0, 4'h0, 20'h0, vcyc, dpc, dseen);
        chk("we_start_new_word", 32'(vcyc), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program-driven instruction source for simple_cpu; sits at the other end of the CPU's 20-bit instruction port and replaces hand-timed testbench stimulus.
- Holds a small program RAM, loaded while idle.
- On start, presents each instruction on the CPU instruction input for a per-class number of cycles, then advances the PC until a HALT word or end of program.

Parameters:
INSTR_WIDTH, 20, instruction width; must match simple_cpu.
PROG_ADDR_BITS, 4, program RAM depth is 2^PROG_ADDR_BITS words.
ALU_HOLD, 3, cycles an ALU instruction (instr[19:18]=01) is held.
LOAD_HOLD, 4, cycles a LOAD_R instruction (instr[19:18]=10) is held.
STORE_HOLD, 3, cycles a STORE_R instruction (instr[19:18]=11) is held.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
prog_we  input  1  program RAM write enable; honoured only in IDLE
prog_addr  input  PROG_ADDR_BITS  program RAM write address
prog_data  input  INSTR_WIDTH  program RAM write data
start  input  1  begin execution from address 0; sampled only in IDLE
instruction  output  INSTR_WIDTH  drives simple_cpu instruction input
instr_valid  output  1  high while instruction carries a live program word
busy  output  1  high in RUN
done  output  1  one-cycle pulse when execution ends
pc  output  PROG_ADDR_BITS  address of the word currently issued

Behaviour:
- Reset (rst=0, async): state=IDLE; instruction=0, instr_valid=0, busy=0, done=0, pc=0; hold counter=0. Program RAM contents are not reset.
- Class decode: instr[19:18]. 00 is HALT; it is never issued. Hold count comes from the matching parameter; a parameter value of 0 is treated as 1.
- IDLE:
  - prog_we=1 writes prog_data into RAM[prog_addr] at the edge.
  - start=1 at an edge sets pc=0. If RAM[0] is HALT: go to DONE. Otherwise: go to RUN, instruction=RAM[0], instr_valid=1, counter=0.
  - start and prog_we both high: the write occurs and start also takes effect; the fetch uses the pre-write contents of address 0.
- RUN:
  - Counter increments every edge.
  - At the edge where counter = hold-1:
    - If pc = 2^PROG_ADDR_BITS-1, or RAM[pc+1] is HALT: go to DONE.
    - Otherwise: pc=pc+1, instruction=RAM[pc+1], counter=0. Issue is back-to-back with no bubble.
  - prog_we and start are ignored in RUN.
- DONE: lasts one cycle. done=1, busy=0, instr_valid=0, instruction=0, pc holds the last issued address. Next edge goes to IDLE.
- Program RAM uses combinational read and synchronous write.
- instruction is registered; it changes only at state or advance edges and is stable for the full hold window.
- Reset asserted mid-RUN: outputs clear immediately; the program is kept; start is needed to rerun.

Optional Feature:
Macro SEQ_LOOP_EN.
- Defined: at the end of the last address, pc wraps to 0 and execution continues with RAM[0] (unless RAM[0] is HALT, which goes to DONE). Only a HALT word ends a run; done is not pulsed at wrap.
- Undefined: the end of the last address always goes to DONE.

Test Plan:
- Load RAM[0..2] = 20'h47000, 20'h53000, 20'h00000; pulse start -> instruction=20'h47000 for exactly 3 cycles, then 20'h53000 for exactly 3 cycles, then a done pulse. pc sequence is 0,1; busy low after done.
- Load RAM[0]=20'hB80F0 (LOAD_R), RAM[1]=0; start -> instruction held for 4 cycles, then done; instr_valid is high for exactly 4 cycles.
- RAM[0]=0; start -> no issue, instr_valid never high; done pulses the cycle after start; pc=0.
- Fill all 16 words with 20'h47000 (no HALT); start -> 16x3 cycles issued, then done at pc=15. With SEQ_LOOP_EN, pc wraps to 0 and done never pulses.
- Assert rst=0 during the 2nd instruction -> instruction=0, busy=0 immediately. After release, start reruns from address 0 with the program intact.
- prog_we=1 to address 1 with a new value during RUN -> RAM unchanged; after done, a rerun issues the original word.
